// File: rtl/mp3_pkg.sv
// Shared definitions for the MPEG-1 Layer III header parser: header field positions,
// sync pattern, bitrate / sample-rate lookup tables and the parser state encoding.
package mp3_pkg;

    localparam logic [10:0] SYNC = 11'h7FF;

    localparam int SYNC_LSB     = 21;
    localparam int VER_LSB      = 19;
    localparam int LAYER_LSB    = 17;
    localparam int PROT_BIT     = 16;
    localparam int BR_LSB       = 12;
    localparam int SR_LSB       = 10;
    localparam int PAD_BIT      = 9;
    localparam int MODE_LSB     = 6;
    localparam int MODE_EXT_LSB = 4;

    localparam logic [1:0] VER_MPEG1 = 2'b11;
    localparam logic [1:0] LAYER_III = 2'b01;

    // Layer III frame length numerator is 144 * bitrate in bit/s.
    localparam int BPS_X144_PER_KBPS = 144000;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CHECK   = 2'd1,
        ST_DIVIDE  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic [8:0] bitrate_kbps(input logic [3:0] idx);
        case (idx)
            4'd1:    return 9'd32;
            4'd2:    return 9'd40;
            4'd3:    return 9'd48;
            4'd4:    return 9'd56;
            4'd5:    return 9'd64;
            4'd6:    return 9'd80;
            4'd7:    return 9'd96;
            4'd8:    return 9'd112;
            4'd9:    return 9'd128;
            4'd10:   return 9'd160;
            4'd11:   return 9'd192;
            4'd12:   return 9'd224;
            4'd13:   return 9'd256;
            4'd14:   return 9'd320;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [15:0] sample_rate_hz(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'd44100;
            2'd1:    return 16'd48000;
            2'd2:    return 16'd32000;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/mp3_frame_divider.sv
// Restoring divider, one quotient bit per cycle; start loads the operands and done
// pulses after exactly DIVIDEND_W iterations. The remainder is not exported.
module mp3_frame_divider #(
    parameter int DIVIDEND_W = 26,
    parameter int DIVISOR_W  = 16,
    parameter int QUOT_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [QUOT_W-1:0]     quotient_o
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [DIVISOR_W:0]    rem_shift;
    logic                  fits;

    // The dividend register doubles as the quotient: its MSB shifts into the
    // partial remainder while the new quotient bit enters at the LSB.
    always_comb begin
        rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (start_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = CNT_W'(DIVIDEND_W);
        end else if (cnt_q != '0) begin
            rem_d  = fits ? (rem_shift[DIVISOR_W-1:0] - dvs_q) : rem_shift[DIVISOR_W-1:0];
            quo_d  = {quo_q[DIVIDEND_W-2:0], fits};
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = (cnt_q != '0);
    assign done_o     = done_q;
    assign quotient_o = quo_q[QUOT_W-1:0];

endmodule

// File: rtl/mp3_header_parser.sv
// MPEG-1 Layer III frame header parser: collects four header bytes, validates them and
// computes the frame length floor(144*bitrate/sample_rate) + padding.
module mp3_header_parser
    import mp3_pkg::*;
#(
    parameter int DIVIDEND_W = 26,
    parameter int DIVISOR_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_v,
    output logic        busy,
    output logic        header_iv,
    output logic        header_err,
    output logic        overrun,
    output logic [1:0]  mode,
    output logic [1:0]  mode_ext,
    output logic        prot,
    output logic [1:0]  sr_idx,
    output logic        padding,
    output logic [10:0] frame_size,
    output logic [31:0] header_word,
    output logic [1:0]  dbg_state_o
);
    // din_v qualifies din with no back-pressure: a byte presented while busy is high
    // (including the DONE edge) is dropped and flagged on overrun one cycle later.

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] hdr_q, hdr_d;
    logic        busy_q, busy_d;
    logic        iv_q, iv_d;
    logic        err_q, err_d;
    logic        err_pend_q, err_pend_d;
    logic        ovr_q, ovr_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  mode_ext_q, mode_ext_d;
    logic        prot_q, prot_d;
    logic [1:0]  sr_idx_q, sr_idx_d;
    logic        pad_q, pad_d;
    logic [10:0] fsize_q, fsize_d;
    logic [31:0] word_q, word_d;

    logic                  hdr_ok;
    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [10:0]           quotient;

    assign hdr_ok = (hdr_q[SYNC_LSB +: 11] == SYNC)
                 && (hdr_q[VER_LSB +: 2] == VER_MPEG1)
                 && (hdr_q[LAYER_LSB +: 2] == LAYER_III)
                 && (hdr_q[BR_LSB +: 4] != 4'd0)
                 && (hdr_q[BR_LSB +: 4] != 4'd15)
                 && (hdr_q[SR_LSB +: 2] != 2'd3);

    assign dividend = DIVIDEND_W'(bitrate_kbps(hdr_q[BR_LSB +: 4])) * DIVIDEND_W'(BPS_X144_PER_KBPS);
    assign divisor  = DIVISOR_W'(sample_rate_hz(hdr_q[SR_LSB +: 2]));

    mp3_frame_divider #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .QUOT_W     (11)
    ) u_divider (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hdr_d      = hdr_q;
        busy_d     = busy_q;
        iv_d       = 1'b0;
        err_d      = err_pend_q;
        err_pend_d = 1'b0;
        ovr_d      = din_v && busy_q;
        mode_d     = mode_q;
        mode_ext_d = mode_ext_q;
        prot_d     = prot_q;
        sr_idx_d   = sr_idx_q;
        pad_d      = pad_q;
        fsize_d    = fsize_q;
        word_d     = word_q;
        div_start  = 1'b0;

        // A rejected header keeps busy up for one extra cycle so the error pulse
        // and the busy fall land on the same edge.
        if (err_pend_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_COLLECT: begin
                if (din_v && !busy_q) begin
                    hdr_d = {hdr_q[23:0], din};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_CHECK;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (hdr_ok) begin
                    div_start = !div_busy;
                    state_d   = ST_DIVIDE;
                end else begin
                    err_pend_d = 1'b1;
                    state_d    = ST_COLLECT;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                iv_d       = 1'b1;
                busy_d     = 1'b0;
                mode_d     = hdr_q[MODE_LSB +: 2];
                mode_ext_d = hdr_q[MODE_EXT_LSB +: 2];
                prot_d     = hdr_q[PROT_BIT];
                sr_idx_d   = hdr_q[SR_LSB +: 2];
                pad_d      = hdr_q[PAD_BIT];
                fsize_d    = quotient + {10'd0, hdr_q[PAD_BIT]};
                word_d     = hdr_q;
                state_d    = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            idx_q      <= '0;
            hdr_q      <= '0;
            busy_q     <= 1'b0;
            iv_q       <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            ovr_q      <= 1'b0;
            mode_q     <= '0;
            mode_ext_q <= '0;
            prot_q     <= 1'b0;
            sr_idx_q   <= '0;
            pad_q      <= 1'b0;
            fsize_q    <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hdr_q      <= hdr_d;
            busy_q     <= busy_d;
            iv_q       <= iv_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
            ovr_q      <= ovr_d;
            mode_q     <= mode_d;
            mode_ext_q <= mode_ext_d;
            prot_q     <= prot_d;
            sr_idx_q   <= sr_idx_d;
            pad_q      <= pad_d;
            fsize_q    <= fsize_d;
            word_q     <= word_d;
        end
    end

    assign busy        = busy_q;
    assign header_iv   = iv_q;
    assign header_err  = err_q;
    assign overrun     = ovr_q;
    assign mode        = mode_q;
    assign mode_ext    = mode_ext_q;
    assign prot        = prot_q;
    assign sr_idx      = sr_idx_q;
    assign padding     = pad_q;
    assign frame_size  = fsize_q;
    assign header_word = word_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mp3_header_parser.sv
// Bench for mp3_header_parser: drivers feed header bytes, a reference model predicts
// results per accepted 4th byte, and a negedge monitor checks pulses, busy and held fields.
module tb_mp3_header_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_v = 1'b0;
  logic        busy, header_iv, header_err, overrun, prot, padding;
  logic [1:0]  mode, mode_ext, sr_idx, dbg_state;
  logic [10:0] frame_size;
  logic [31:0] header_word;

  always #5 clk = ~clk;

  mp3_header_parser dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_v       (din_v),
    .busy        (busy),
    .header_iv   (header_iv),
    .header_err  (header_err),
    .overrun     (overrun),
    .mode        (mode),
    .mode_ext    (mode_ext),
    .prot        (prot),
    .sr_idx      (sr_idx),
    .padding     (padding),
    .frame_size  (frame_size),
    .header_word (header_word),
    .dbg_state_o (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] due;
    logic        valid;
    logic [50:0] fields;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int               ovr_q[$];

  int br_kbps[16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
  int sr_hz[4]    = '{44100, 48000, 32000, 0};

  logic [31:0] acc = '0;
  int          nacc = 0;
  int          busy_from = 0;
  int          busy_until = 0;
  logic [50:0] hold = '0;

  function automatic logic header_ok(input logic [31:0] w);
    return (w[31:21] == 11'h7FF) && (w[20:19] == 2'b11) && (w[18:17] == 2'b01)
        && (w[15:12] != 4'd0) && (w[15:12] != 4'd15) && (w[11:10] != 2'd3);
  endfunction

  function automatic logic [50:0] header_fields(input logic [31:0] w);
    int fs;
    fs = (144 * br_kbps[w[15:12]] * 1000) / sr_hz[w[11:10]] + int'(w[9]);
    return {w[7:6], w[5:4], w[16], w[11:10], w[9], 11'(fs), w};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h, required %0h", name, edge_cnt, act, req);
    end
  endtask

  // c is the clock edge at which the DUT samples this byte.
  task automatic model_byte(input int c, input logic [7:0] b);
    exp_t e;
    if (c <= busy_until) begin
      ovr_q.push_back(c);
    end else begin
      acc = {acc[23:0], b};
      nacc++;
      if (nacc == 4) begin
        nacc     = 0;
        e.valid  = header_ok(acc);
        e.due    = 32'(c + (e.valid ? 29 : 2));
        e.fields = e.valid ? header_fields(acc) : '0;
        busy_from  = c;
        busy_until = int'(e.due);
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    din   = b;
    din_v = 1'b1;
    model_byte(edge_cnt + 1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_v = 1'b0;
      din   = 8'h00;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) begin
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
      send_byte(w[i*8 +: 8]);
    end
    idle(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_iv"}, 64'(header_iv), 64'(0));
    check({tag, "_err"}, 64'(header_err), 64'(0));
    check({tag, "_ovr"}, 64'(overrun), 64'(0));
    check({tag, "_fields"}, 64'({mode, mode_ext, prot, sr_idx, padding, frame_size, header_word}), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  // Reset edge lands on edge_no; model is cleared right after that edge.
  task automatic reset_at(input int edge_no);
    while (edge_cnt < edge_no - 1) @(negedge clk);
    rst   = 1'b1;
    din_v = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    ovr_q.delete();
    nacc       = 0;
    busy_from  = 0;
    busy_until = 0;
    hold       = '0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    logic exp_pulse;
    logic exp_ovr;
    if (edge_cnt > 0) begin
      exp_pulse = 1'b0;
      e = '0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (int'(e.due) == edge_cnt) begin
          exp_pulse = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      if (exp_pulse && e.valid) hold = e.fields;
      if (exp_pulse || header_iv || header_err) begin
        check("header_iv", 64'(header_iv), 64'(exp_pulse && e.valid));
        check("header_err", 64'(header_err), 64'(exp_pulse && !e.valid));
      end
      exp_ovr = (ovr_q.size() > 0) && (ovr_q[0] == edge_cnt);
      if (exp_ovr) void'(ovr_q.pop_front());
      if (exp_ovr || overrun) check("overrun", 64'(overrun), 64'(exp_ovr));
      check("busy", 64'(busy), 64'(edge_cnt >= busy_from && edge_cnt < busy_until));
      check("held_fields", 64'({mode, mode_ext, prot, sr_idx, padding, frame_size, header_word}),
            64'(hold));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    send_word(32'hFFFB9000, 0);
    idle(35);
    check("fs_128k_44k", 64'(frame_size), 64'(417));
    check("mode_stereo", 64'(mode), 64'(0));
    check("prot_nocrc", 64'(prot), 64'(1));

    send_word(32'hFFFB92C0, 0);
    idle(35);
    check("fs_pad", 64'(frame_size), 64'(418));
    check("mode_mono", 64'(mode), 64'(3));
    check("padding", 64'(padding), 64'(1));

    send_word(32'hFFFBE400, 0);
    idle(35);
    check("fs_320k_48k", 64'(frame_size), 64'(960));
    send_word(32'hFFFB1000, 0);
    idle(35);
    check("fs_32k_44k", 64'(frame_size), 64'(104));
    send_word(32'hFFFA1800, 0);
    idle(35);
    check("fs_32k_32k", 64'(frame_size), 64'(144));
    check("prot_crc", 64'(prot), 64'(0));

    send_word(32'hFFFBF000, 0);
    idle(5);
    send_word(32'hFFFB9C00, 0);
    idle(5);
    send_word(32'hFFF39000, 0);
    idle(5);
    send_word(32'hFEFB9000, 0);
    idle(5);
    check("err_keeps_fs", 64'(frame_size), 64'(144));
    check("err_keeps_word", 64'(header_word), 64'(32'hFFFA1800));

    // Gapped bytes, then extra bytes while the divider runs.
    send_word(32'hFFFB9000, 3);
    idle(5);
    repeat (3) begin
      send_byte(8'($urandom));
      idle($urandom_range(3, 0));
    end
    idle(30);
    check("fs_after_overrun", 64'(frame_size), 64'(417));

    // Byte on the error edge is dropped, the next one is accepted.
    send_word(32'hFFF39000, 0);
    send_byte(8'h5A);
    send_word(32'hFFFB1000, 0);
    idle(35);
    check("fs_after_err_edge", 64'(frame_size), 64'(104));

    // Byte on the DONE edge is dropped, the next header decodes.
    send_word(32'hFFFB9000, 0);
    while (edge_cnt < busy_from + 27) @(negedge clk);
    send_byte(8'hA5);
    send_word(32'hFFFB92C0, 0);
    idle(35);
    check("fs_after_done_edge", 64'(frame_size), 64'(418));

    // Reset during the divide aborts without a pulse.
    send_word(32'hFFFBE400, 0);
    reset_at(busy_from + 10);
    idle(35);
    send_word(32'hFFFB9000, 0);
    idle(35);
    check("fs_after_reset", 64'(frame_size), 64'(417));

    for (int n = 0; n < 40; n++) begin
      logic [31:0] w;
      if ($urandom_range(3, 0) == 0) w = $urandom();
      else w = {11'h7FF, 2'b11, 2'b01, 1'($urandom), 4'($urandom), 2'($urandom), 10'($urandom)};
      send_word(w, 2);
      idle($urandom_range(32, 0));
      if ($urandom_range(3, 0) == 0) begin
        send_byte(8'($urandom));
        idle(1);
      end
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
